// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter with a 32-slot frame, MSB first,
// a one-entry sample buffer and a sticky underrun flag.
module i2s_tx (
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] i2s_aud_in,
    input  logic        i2s_aud_in_rts,
    output logic        i2s_aud_in_rtr,
    input  logic        rf_i2s_en,
    input  logic [7:0]  rf_bclk_div,
    input  logic        trig_i2s_underrun_flag_clear,
    output logic        ro_i2s_underrun_flag,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
);

    logic [7:0]  div_q, div_d;
    logic        bclk_q, bclk_d;
    logic        lrclk_q, lrclk_d;
    logic        sdata_q, sdata_d;
    logic [4:0]  slot_q, slot_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] buf_q, buf_d;
    logic        bufv_q, bufv_d;
    logic        flag_q, flag_d;

    logic        tick;
    logic        fall;
    logic        frame_start;
    logic        capture;
    logic [4:0]  slot_nx;
    logic [31:0] shift_ld;

    // Reset gates rtr so no handshake can complete while held in reset.
    assign i2s_aud_in_rtr       = rstb && rf_i2s_en && !bufv_q;
    assign ro_i2s_underrun_flag = flag_q;
    assign i2s_bclk             = bclk_q;
    assign i2s_lrclk            = lrclk_q;
    assign i2s_sdata            = sdata_q;

    always_comb begin
        tick        = rf_i2s_en && (div_q >= rf_bclk_div);
        fall        = tick && bclk_q;
        slot_nx     = slot_q + 5'd1;
        frame_start = fall && (slot_nx == 5'd0);
        capture     = i2s_aud_in_rts && i2s_aud_in_rtr;
        shift_ld    = shift_q;

        div_d   = div_q;
        bclk_d  = bclk_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        slot_d  = slot_q;
        shift_d = shift_q;
        buf_d   = buf_q;
        bufv_d  = bufv_q;

        if (!rf_i2s_en) begin
            div_d   = 8'd0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
            slot_d  = 5'd31;
            shift_d = 32'h0;
            bufv_d  = 1'b0;
        end else begin
            div_d = tick ? 8'd0 : div_q + 8'd1;
            if (tick) begin
                bclk_d = ~bclk_q;
            end
            if (fall) begin
                if (frame_start) begin
                    shift_ld = bufv_q ? buf_q : 32'h0;
                    bufv_d   = 1'b0;
                end
                slot_d  = slot_nx;
                shift_d = shift_ld;
                sdata_d = shift_ld[5'd31 - slot_nx];
                lrclk_d = (slot_nx >= 5'd15) && (slot_nx <= 5'd30);
            end
            if (capture) begin
                buf_d  = i2s_aud_in;
                bufv_d = 1'b1;
            end
        end

        flag_d = flag_q;
        if (frame_start && !bufv_q) begin
            flag_d = 1'b1;
        end else if (trig_i2s_underrun_flag_clear) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            div_q   <= 8'd0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            slot_q  <= 5'd31;
            shift_q <= 32'h0;
            buf_q   <= 32'h0;
            bufv_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            slot_q  <= slot_d;
            shift_q <= shift_d;
            buf_q   <= buf_d;
            bufv_q  <= bufv_d;
            flag_q  <= flag_d;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized and directed bench for i2s_tx with a
// frame-level reference model and a scoreboard of accepted samples.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [31:0] aud = 32'h0;
    logic        rts = 1'b0;
    logic        rtr;
    logic        en = 1'b0;
    logic [7:0]  div = 8'd1;
    logic        clr = 1'b0;
    logic        flag;
    logic        bclk;
    logic        lrclk;
    logic        sdata;

    always #5 clk = ~clk;

    i2s_tx dut (
        .clk                          (clk),
        .rstb                         (rstb),
        .i2s_aud_in                   (aud),
        .i2s_aud_in_rts               (rts),
        .i2s_aud_in_rtr               (rtr),
        .rf_i2s_en                    (en),
        .rf_bclk_div                  (div),
        .trig_i2s_underrun_flag_clear (clr),
        .ro_i2s_underrun_flag         (flag),
        .i2s_bclk                     (bclk),
        .i2s_lrclk                    (lrclk),
        .i2s_sdata                    (sdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: accepted-sample queue, slot position, flag.
    logic [31:0] exp_q[$];
    int          m_slot = 31;
    bit          in_frame = 0;
    logic [31:0] cur = 32'h0;
    logic [31:0] got = 32'h0;
    logic [31:0] last_word = 32'h0;
    int          frames = 0;
    bit          flag_m = 0;
    int          cyc = 0;
    bit          skip = 0;
    bit          u_set = 0;
    logic        prev_bclk = 1'b0;
    logic [7:0]  div_prev = 8'd0;
    longint      cyc_n = 0;
    longint      load_cyc = 0;
    bit          chk_b2b = 0;

    bit          p_rst, p_en, p_clr, p_hs;
    logic [31:0] p_data;
    logic [7:0]  p_div;

    // Inputs as seen by each rising edge.
    always @(posedge clk) begin
        cyc_n++;
        p_rst  = !rstb;
        p_en   = en;
        p_clr  = clr;
        p_data = aud;
        p_div  = div;
        p_hs   = rstb && en && rts && (exp_q.size() == 0);
        if (p_hs && chk_b2b)
            check("b2b_accept_lat", (cyc_n - load_cyc) <= 1, 1);
    end

    // Monitor: apply the effect of the last rising edge, compare.
    always @(negedge clk) begin
        u_set = 0;
        if (!rstb || p_rst) begin
            exp_q.delete();
            m_slot = 31; in_frame = 0; flag_m = 0; cyc = 0; skip = 0;
            div_prev = div;
            check("rst_out", {bclk, lrclk, sdata, rtr, flag}, 0);
        end else if (!p_en) begin
            exp_q.delete();
            m_slot = 31; in_frame = 0; cyc = 0; skip = 0;
            if (p_clr) flag_m = 0;
            div_prev = p_div;
            check("dis_out", {bclk, lrclk, sdata}, 0);
        end else begin
            cyc++;
            if (p_div != div_prev) skip = 1;
            div_prev = p_div;
            if (bclk != prev_bclk) begin
                if (!skip) check("bclk_half", cyc, p_div + 1);
                cyc = 0; skip = 0;
                if (prev_bclk) begin
                    m_slot = (m_slot + 1) % 32;
                    if (m_slot == 0) begin
                        in_frame = 1;
                        load_cyc = cyc_n;
                        if (exp_q.size() > 0) cur = exp_q.pop_front();
                        else begin cur = 32'h0; u_set = 1; end
                    end
                    check("lrclk", lrclk, (m_slot >= 15 && m_slot <= 30));
                    if (in_frame) begin
                        got[31 - m_slot] = sdata;
                        if (m_slot == 31) begin
                            check("frame", got, cur);
                            last_word = got;
                            frames++;
                        end
                    end
                end
            end
            if (u_set) flag_m = 1;
            else if (p_clr) flag_m = 0;
            if (p_hs) exp_q.push_back(p_data);
        end
        prev_bclk = bclk;
        check("rtr", rtr, rstb && en && (exp_q.size() == 0));
        check("flag", flag, flag_m);
    end

    task automatic send(input logic [31:0] w, input bit keep);
        int n = 0;
        bit ok = 0;
        aud = w; rts = 1'b1;
        while (!ok && n < 20000) begin
            @(negedge clk); #1; n++;
            if (rstb && en && exp_q.size() == 0) begin
                @(posedge clk); #1; ok = 1;
            end
        end
        check("send_timeout", ok, 1);
        if (!keep) rts = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 20000) begin
            @(negedge clk); #1; n++;
        end
        check("frame_timeout", frames >= target, 1);
    endtask

    task automatic wait_slot(input int s);
        int n = 0;
        while (!(in_frame && m_slot == s) && n < 20000) begin
            @(negedge clk); #1; n++;
        end
        check("slot_timeout", in_frame && m_slot == s, 1);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic wait_toggles(input int k, output int last_gap);
        int n = 0;
        int c = 0;
        logic b;
        last_gap = 0;
        @(negedge clk); #1; b = bclk;
        while (k > 0 && n < 4000) begin
            @(negedge clk); #1; n++; c++;
            if (bclk != b) begin k--; last_gap = c; c = 0; b = bclk; end
        end
        check("toggle_timeout", k, 0);
    endtask

    initial begin
        int n;
        int gap;
        logic b;
        logic [31:0] w;

        repeat (3) @(negedge clk);
        #1 rstb = 1'b1;
        @(posedge clk); #1;

        // Basic frame
        div = 8'd1; en = 1'b1;
        send(32'hA5F0_0F5A, 0);
        wait_frames(frames + 1);
        check("basic_frame", last_word, 32'hA5F0_0F5A);

        // Underrun: next frame with no sample
        wait_frames(frames + 1);
        check("underrun_word", last_word, 0);
        check("underrun_flag", flag, 1);
        wait_slot(2);
        pulse_clear();
        @(negedge clk); #1;
        check("clear_flag", flag, 0);

        // Clear in the same cycle as a slot-0 underrun
        n = 0;
        while (!(m_slot == 31 && bclk && cyc == div) && n < 4000) begin
            @(negedge clk); #1; n++;
        end
        check("slot31_timeout", n < 4000, 1);
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk); #1;
        check("set_beats_clear", flag, 1);

        // Back-to-back frames
        send($urandom, 1);
        chk_b2b = 1;
        pulse_clear();
        send($urandom, 1);
        send($urandom, 0);
        chk_b2b = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk); #1; n++;
        end
        check("b2b_no_underrun", flag, 0);
        wait_frames(frames + 1);

        // Random samples at a random small divider
        for (int i = 0; i < 4; i++) begin
            div = 8'($urandom_range(0, 3));
            w = $urandom;
            send(w, 0);
            wait_frames(frames + 1);
        end

        // Divider extremes
        div = 8'd0;
        send($urandom, 0);
        wait_frames(frames + 2);
        div = 8'd255;
        wait_toggles(3, gap);
        check("div255_half", gap, 256);
        send($urandom, 0);
        n = 0;
        while (cyc < 100 && n < 1000) begin
            @(negedge clk); #1; n++;
        end
        b = bclk;
        div = 8'd3;
        @(negedge clk); #1;
        check("div_change_fast", bclk != b, 1);
        wait_frames(frames + 2);

        // Enable abort at slot 10
        div = 8'd1;
        send(32'h1357_9BDF, 0);
        wait_slot(10);
        send(32'hDEAD_BEEF, 0);
        @(negedge clk); #1 en = 1'b0;
        @(negedge clk); #1;
        check("en_abort_bus", {bclk, lrclk, sdata, rtr}, 0);
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        w = $urandom;
        send(w, 0);
        wait_frames(frames + 1);
        check("reenable_frame", last_word, w);

        // Reset abort at slot 20
        send(32'h2468_ACE0, 0);
        wait_slot(20);
        send(32'h0BAD_F00D, 0);
        @(negedge clk); #1 rstb = 1'b0;
        #1;
        check("rst_abort_bus", {bclk, lrclk, sdata, rtr, flag}, 0);
        repeat (2) @(negedge clk);
        #1 rstb = 1'b1;
        w = $urandom;
        send(w, 0);
        wait_frames(frames + 1);
        check("post_reset_frame", last_word, w);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
